// File: rtl/vga_timing_gen_param.sv
// Raster timing generator: pixel/line position, blanking, H/V sync, line/frame strobes, frame counter.
// Latency: position and frame counter are registers; every decode is combinational from them (zero latency).
// Backpressure: none; counters advance only on cycles where pixEnIn is high and hold otherwise.
module vga_timing_gen_param #(
    parameter int H_VISIBLE  = 800,
    parameter int H_FRONT    = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BACK     = 64,
    parameter int V_VISIBLE  = 600,
    parameter int V_FRONT    = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BACK     = 23,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int POS_W      = 12,
    parameter int FCNT_W     = 16
) (
    input  logic              clkIn,
    input  logic              rstNIn,
    input  logic              pixEnIn,
    output logic [POS_W-1:0]  hPosOut,
    output logic [POS_W-1:0]  vPosOut,
    output logic              isDisplayOnOut,
    output logic              isHSyncOut,
    output logic              isVSyncOut,
    output logic              lineStartOut,
    output logic              frameStartOut,
    output logic [FCNT_W-1:0] frameCntOut
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [POS_W-1:0]  H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0]  V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

    // Range bounds are one bit wider than the position so H_TOTAL == 2^POS_W still compares correctly.
    localparam logic [POS_W:0] H_VIS_END  = (POS_W+1)'(H_VISIBLE);
    localparam logic [POS_W:0] H_SYNC_BEG = (POS_W+1)'(H_VISIBLE + H_FRONT);
    localparam logic [POS_W:0] H_SYNC_END = (POS_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [POS_W:0] V_VIS_END  = (POS_W+1)'(V_VISIBLE);
    localparam logic [POS_W:0] V_SYNC_BEG = (POS_W+1)'(V_VISIBLE + V_FRONT);
    localparam logic [POS_W:0] V_SYNC_END = (POS_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    // Reject configurations whose totals do not fit the position width or that have no sync pulse.
    if (H_TOTAL > (1 << POS_W)) begin : g_h_total_err
        $error("vga_timing_gen_param: H_TOTAL %0d exceeds 2^POS_W", H_TOTAL);
    end
    if (V_TOTAL > (1 << POS_W)) begin : g_v_total_err
        $error("vga_timing_gen_param: V_TOTAL %0d exceeds 2^POS_W", V_TOTAL);
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_sync_width_err
        $error("vga_timing_gen_param: sync widths must be non-zero");
    end

    logic [POS_W-1:0]  r_hPos;
    logic [POS_W-1:0]  r_vPos;
    logic [FCNT_W-1:0] r_frameCnt;

    logic w_hVisible;
    logic w_vVisible;
    logic w_hActive;
    logic w_vActive;
    logic w_atLineStart;

    // Raster position and completed-frame counter; a frame only counts once its last pixel has passed.
    always_ff @(posedge clkIn) begin
        if (!rstNIn) begin
            r_hPos     <= '0;
            r_vPos     <= '0;
            r_frameCnt <= '0;
        end else if (pixEnIn) begin
            if (r_hPos == H_LAST) begin
                r_hPos <= '0;
                if (r_vPos == V_LAST) begin
                    r_vPos     <= '0;
                    r_frameCnt <= r_frameCnt + FCNT_ONE;
                end else begin
                    r_vPos <= r_vPos + POS_ONE;
                end
            end else begin
                r_hPos <= r_hPos + POS_ONE;
            end
        end
    end

    // Region decodes straight from the position registers.
    always_comb begin
        w_hVisible    = 1'b0;
        w_vVisible    = 1'b0;
        w_hActive     = 1'b0;
        w_vActive     = 1'b0;
        w_atLineStart = 1'b0;
        w_hVisible    = ({1'b0, r_hPos} < H_VIS_END);
        w_vVisible    = ({1'b0, r_vPos} < V_VIS_END);
        w_hActive     = ({1'b0, r_hPos} >= H_SYNC_BEG) && ({1'b0, r_hPos} < H_SYNC_END);
        w_vActive     = ({1'b0, r_vPos} >= V_SYNC_BEG) && ({1'b0, r_vPos} < V_SYNC_END);
        w_atLineStart = (r_hPos == '0);
    end

    assign hPosOut        = r_hPos;
    assign vPosOut        = r_vPos;
    assign frameCntOut    = r_frameCnt;
    assign isDisplayOnOut = w_hVisible && w_vVisible;
    assign isHSyncOut     = (H_SYNC_POL != 0) ? w_hActive : !w_hActive;
    assign isVSyncOut     = (V_SYNC_POL != 0) ? w_vActive : !w_vActive;
    assign lineStartOut   = pixEnIn && w_atLineStart;
    assign frameStartOut  = pixEnIn && w_atLineStart && (r_vPos == '0);

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Bench for vga_timing_gen_param: a default-timing instance and a tiny low-polarity instance share stimulus.
// Expected outputs come from a tick-count model (position = tick count mod totals) queued per cycle.
// A negedge monitor pops each queue and compares every output.
module tb_vga_timing_gen_param;

    // Small configuration: H 10/2/3/2 (17 ticks), V 4/1/2/1 (8 lines), active-low syncs, 3-bit frame count.
    localparam int S_HV = 10, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VV = 4,  S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int S_PW = 5,  S_FW = 3;
    localparam int S_FRAME = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;

    typedef struct {
        int h;
        int v;
        int fc;
        bit de;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
    } exp_t;

    logic clk = 1'b0;
    logic rstNIn;
    logic pixEnIn;

    logic [11:0] d_h, d_v;
    logic [15:0] d_fc;
    logic        d_de, d_hs, d_vs, d_ls, d_fs;
    logic [S_PW-1:0] s_h, s_v;
    logic [S_FW-1:0] s_fc;
    logic        s_de, s_hs, s_vs, s_ls, s_fs;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q_d[$];
    exp_t q_s[$];
    longint t_d = 0;
    longint t_s = 0;

    always #5 clk = ~clk;

    vga_timing_gen_param dut_d (
        .clkIn(clk), .rstNIn(rstNIn), .pixEnIn(pixEnIn),
        .hPosOut(d_h), .vPosOut(d_v), .isDisplayOnOut(d_de),
        .isHSyncOut(d_hs), .isVSyncOut(d_vs), .lineStartOut(d_ls),
        .frameStartOut(d_fs), .frameCntOut(d_fc)
    );

    vga_timing_gen_param #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .POS_W(S_PW), .FCNT_W(S_FW)
    ) dut_s (
        .clkIn(clk), .rstNIn(rstNIn), .pixEnIn(pixEnIn),
        .hPosOut(s_h), .vPosOut(s_v), .isDisplayOnOut(s_de),
        .isHSyncOut(s_hs), .isVSyncOut(s_vs), .lineStartOut(s_ls),
        .frameStartOut(s_fs), .frameCntOut(s_fc)
    );

    // Reference: t enabled ticks since reset define the whole raster state.
    function automatic exp_t model(input longint t, input bit en,
                                   input int hv, input int hf, input int hs, input int hb,
                                   input int vv, input int vf, input int vs, input int vb,
                                   input bit hpol, input bit vpol, input int fw);
        exp_t   e;
        longint ht, vt;
        bit     ha, va;
        ht   = hv + hf + hs + hb;
        vt   = vv + vf + vs + vb;
        e.h  = int'(t % ht);
        e.v  = int'((t / ht) % vt);
        e.fc = int'((t / (ht * vt)) % (longint'(1) << fw));
        e.de = (e.h < hv) && (e.v < vv);
        ha   = (e.h >= hv + hf) && (e.h < hv + hf + hs);
        va   = (e.v >= vv + vf) && (e.v < vv + vf + vs);
        e.hs = hpol ? ha : !ha;
        e.vs = vpol ? va : !va;
        e.ls = en && (e.h == 0);
        e.fs = en && (e.h == 0) && (e.v == 0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected during it, then advance the model.
    task automatic step(input logic rst_n, input logic en);
        rstNIn  = rst_n;
        pixEnIn = en;
        q_d.push_back(model(t_d, en, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1, 16));
        q_s.push_back(model(t_s, en, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1'b0, 1'b0, S_FW));
        if (!rst_n) begin
            t_d = 0;
            t_s = 0;
        end else begin
            t_d += longint'(en);
            t_s += longint'(en);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUTs present a full set of outputs; compare against the queued entry.
    always @(negedge clk) begin
        exp_t e;
        if (q_d.size() > 0) begin
            e = q_d.pop_front();
            check("d_hpos",  32'(d_h),  32'(e.h));
            check("d_vpos",  32'(d_v),  32'(e.v));
            check("d_fcnt",  32'(d_fc), 32'(e.fc));
            check("d_disp",  32'(d_de), 32'(e.de));
            check("d_hsync", 32'(d_hs), 32'(e.hs));
            check("d_vsync", 32'(d_vs), 32'(e.vs));
            check("d_lstrt", 32'(d_ls), 32'(e.ls));
            check("d_fstrt", 32'(d_fs), 32'(e.fs));
        end
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            check("s_hpos",  32'(s_h),  32'(e.h));
            check("s_vpos",  32'(s_v),  32'(e.v));
            check("s_fcnt",  32'(s_fc), 32'(e.fc));
            check("s_disp",  32'(s_de), 32'(e.de));
            check("s_hsync", 32'(s_hs), 32'(e.hs));
            check("s_vsync", 32'(s_vs), 32'(e.vs));
            check("s_lstrt", 32'(s_ls), 32'(e.ls));
            check("s_fstrt", 32'(s_fs), 32'(e.fs));
        end
    end

    initial begin
        int     guard;
        longint target;
        rstNIn  = 1'b0;
        pixEnIn = 1'b0;
        // First edge loads the reset state; checking starts once registers are defined.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // Continuous pixel clock: covers the 1039 -> 0 wrap on the default instance and many small frames.
        for (int i = 0; i < 1100; i++) step(1'b1, 1'b1);

        // Enable on every second cycle.
        for (int i = 0; i < 400; i++) step(1'b1, 1'(i % 2));

        // Irregular enable until the small instance sits mid-frame (frame count 5, line 3, pixel 9).
        target = 13 * S_FRAME + 3 * S_HT + 9;
        guard  = 0;
        while (t_s != target && guard < 5000) begin
            step(1'b1, 1'($urandom_range(0, 1)));
            guard++;
        end
        check("midframe_reach", 32'(t_s == target), 32'd1);

        // One reset cycle mid-frame, then resume with irregular enable.
        step(1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) step(1'b1, 1'($urandom_range(0, 3) != 0));

        // Long run of continuous ticks so the default instance walks many lines.
        for (int i = 0; i < 6000; i++) step(1'b1, 1'b1);

        guard = 0;
        while ((q_d.size() > 0 || q_s.size() > 0) && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        check("queue_drained", 32'(q_d.size() + q_s.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
